// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative LC-3b cache: hit handling, dirty
// writeback, line fill and saturating hit/miss/writeback event counters.
module cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  input  logic                 is_hit,
  input  logic                 hit_sel,
  input  logic                 Dout_Valid0,
  input  logic                 Dout_Valid1,
  input  logic                 Dout_Dirty0,
  input  logic                 Dout_Dirty1,
  input  logic                 Dout_LRU,
  input  logic                 pmem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [1:0]           w_Data,
  output logic [1:0]           w_Tag,
  output logic [1:0]           w_Valid,
  output logic [1:0]           w_Dirty,
  output logic                 w_LRU,
  output logic                 Din_LRU,
  output logic                 Din_Valid,
  output logic                 Din_Dirty,
  output logic                 data_sel,
  output logic                 addr_sel,
  output logic                 victim_way,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  localparam logic [1:0] IDLE      = 2'b00;
  localparam logic [1:0] WRITEBACK = 2'b01;
  localparam logic [1:0] ALLOCATE  = 2'b10;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [1:0]           state_r;
  logic [1:0]           state_next_s;
  logic                 victim_r;
  logic                 victim_next_s;
  logic                 req_s;
  logic                 hit_s;
  logic                 miss_way_s;
  logic                 miss_dirty_s;
  logic                 hit_inc_s;
  logic                 miss_inc_s;
  logic                 wb_inc_s;
  logic [CNT_WIDTH-1:0] hit_count_r;
  logic [CNT_WIDTH-1:0] miss_count_r;
  logic [CNT_WIDTH-1:0] wb_count_r;

  function automatic logic [1:0] way_mask(input logic way);
    return way ? 2'b10 : 2'b01;
  endfunction

  // Empty ways are filled before anything valid is evicted.
  function automatic logic pick_victim(input logic v0, input logic v1, input logic lru);
    if (!v0) begin
      return 1'b0;
    end else if (!v1) begin
      return 1'b1;
    end else begin
      return lru;
    end
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  endfunction

  assign req_s        = mem_read | mem_write;
  assign hit_s        = is_hit & (hit_sel ? Dout_Valid1 : Dout_Valid0);
  assign miss_way_s   = pick_victim(Dout_Valid0, Dout_Valid1, Dout_LRU);
  assign miss_dirty_s = miss_way_s ? (Dout_Valid1 & Dout_Dirty1)
                                   : (Dout_Valid0 & Dout_Dirty0);

  assign victim_way = victim_r;
  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;
  assign wb_count   = wb_count_r;

  // Next-state and output decode; rst forces every output low immediately.
  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    w_Data        = 2'b00;
    w_Tag         = 2'b00;
    w_Valid       = 2'b00;
    w_Dirty       = 2'b00;
    w_LRU         = 1'b0;
    Din_LRU       = 1'b0;
    Din_Valid     = 1'b0;
    Din_Dirty     = 1'b0;
    data_sel      = 1'b0;
    addr_sel      = 1'b0;
    state_next_s  = state_r;
    victim_next_s = victim_r;
    hit_inc_s     = 1'b0;
    miss_inc_s    = 1'b0;
    wb_inc_s      = 1'b0;
    if (rst) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s && hit_s) begin
            mem_resp  = 1'b1;
            w_LRU     = 1'b1;
            Din_LRU   = ~hit_sel;
            hit_inc_s = 1'b1;
            // A simultaneous read+write is treated as a write.
            if (mem_write) begin
              w_Data    = way_mask(hit_sel);
              w_Dirty   = way_mask(hit_sel);
              Din_Dirty = 1'b1;
            end else begin
              data_sel  = 1'b0;
            end
          end else if (req_s) begin
            victim_next_s = miss_way_s;
            miss_inc_s    = 1'b1;
            state_next_s  = miss_dirty_s ? WRITEBACK : ALLOCATE;
          end else begin
            state_next_s = IDLE;
          end
        end
        WRITEBACK: begin
          pmem_write = 1'b1;
          addr_sel   = 1'b1;
          if (pmem_resp) begin
            w_Dirty      = way_mask(victim_r);
            Din_Dirty    = 1'b0;
            wb_inc_s     = 1'b1;
            state_next_s = ALLOCATE;
          end else begin
            state_next_s = WRITEBACK;
          end
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          addr_sel  = 1'b0;
          // The fill completes even if the CPU dropped its request.
          if (pmem_resp) begin
            w_Data       = way_mask(victim_r);
            data_sel     = 1'b1;
            w_Tag        = way_mask(victim_r);
            w_Valid      = way_mask(victim_r);
            Din_Valid    = 1'b1;
            w_Dirty      = way_mask(victim_r);
            Din_Dirty    = 1'b0;
            state_next_s = IDLE;
          end else begin
            state_next_s = ALLOCATE;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // FSM state and the victim way latched on an IDLE miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      victim_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      victim_r <= victim_next_s;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_r  <= {CNT_WIDTH{1'b0}};
      miss_count_r <= {CNT_WIDTH{1'b0}};
      wb_count_r   <= {CNT_WIDTH{1'b0}};
    end else begin
      if (hit_inc_s) begin
        hit_count_r <= sat_inc(hit_count_r);
      end
      if (miss_inc_s) begin
        miss_count_r <= sat_inc(miss_count_r);
      end
      if (wb_inc_s) begin
        wb_count_r <= sat_inc(wb_count_r);
      end
    end
  end

endmodule
